// File: rtl/alu_seq_if.sv
// alu_seq_if: decoder/register-file/ALU bundle around the ALU issue sequencer
// slave modport: the sequencer (takes instructions, drives rf write and alu_* inputs)
// master modport: the surrounding core (decoder, register file, ALU)
interface alu_seq_if;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic [3:0]  rf_rd_addr;
  logic [3:0]  rf_rr_addr;
  logic [7:0]  rf_rd_data;
  logic [7:0]  rf_rr_data;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [7:0]  rf_wdata;
  logic [7:0]  alu_opcode;
  logic [7:0]  alu_data_rd;
  logic [7:0]  alu_data_rr;
  logic        alu_ci;
  logic [15:0] alu_data_o;
  logic        alu_co;
  logic        alu_zo;
  logic        alu_no;
  logic        flag_c;
  logic        flag_z;
  logic        flag_n;
  logic        op_done;
  logic        illegal_op;
  logic [15:0] op_count;
  modport slave (
    input  instr_valid, instr, rf_rd_data, rf_rr_data, alu_data_o, alu_co, alu_zo, alu_no,
    output instr_ready, rf_rd_addr, rf_rr_addr, rf_we, rf_waddr, rf_wdata,
           alu_opcode, alu_data_rd, alu_data_rr, alu_ci, flag_c, flag_z, flag_n,
           op_done, illegal_op, op_count
  );
  modport master (
    output instr_valid, instr, rf_rd_data, rf_rr_data, alu_data_o, alu_co, alu_zo, alu_no,
    input  instr_ready, rf_rd_addr, rf_rr_addr, rf_we, rf_waddr, rf_wdata,
           alu_opcode, alu_data_rd, alu_data_rr, alu_ci, flag_c, flag_z, flag_n,
           op_done, illegal_op, op_count
  );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: issues one ALU instruction, waits ALU_LAT cycles, writes back result and C/Z/N flags
// Ports: clk, rst (async, active high), bus (alu_seq_if.slave: instruction handshake,
//   register-file read/write, registered ALU inputs, ALU results, status flags, op_done, illegal_op, op_count)
// Optional: define ALU_SEQ_PERF_EN to build the legal-issue counter on op_count (tied to 0 otherwise)
module alu_sequencer #(
  parameter int ALU_LAT = 2,
  parameter int NREGS   = 16
) (
  input logic       clk,
  input logic       rst,
  alu_seq_if.slave  bus
);
  localparam int RW = $clog2(NREGS);
  localparam int CW = ALU_LAT > 1 ? $clog2(ALU_LAT) : 1;
  localparam logic [CW-1:0] LAST = CW'(ALU_LAT - 1);
  typedef enum logic [1:0] {IDLE, EXEC, WB_LO, WB_HI} state_t;
  state_t        state;
  logic [RW-1:0] rd;
  logic [CW-1:0] cnt;
  logic [7:0]    op;
  logic          legal;
  logic          mult;
  assign op    = bus.instr[15:8];
  assign legal = !op[7] || op[7:4] == 4'h8 || (op[7:4] == 4'h9 && op[1:0] == 2'b00);
  assign mult  = bus.alu_opcode[7:4] == 4'h3;
  assign bus.instr_ready = state == IDLE;
  assign bus.rf_rd_addr  = bus.instr[7:4];
  assign bus.rf_rr_addr  = bus.instr[3:0];
  assign bus.rf_we       = state == WB_LO || state == WB_HI;
  // the high byte of a MULT lands in the next register, wrapping at the top of the file
  assign bus.rf_waddr    = state == WB_HI ? rd + 1'b1 : rd;
  assign bus.rf_wdata    = state == WB_HI ? bus.alu_data_o[15:8] : bus.alu_data_o[7:0];
  assign bus.op_done     = state == WB_HI || (state == WB_LO && !mult);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      rd              <= '0;
      cnt             <= '0;
      bus.alu_opcode  <= '0;
      bus.alu_data_rd <= '0;
      bus.alu_data_rr <= '0;
      bus.alu_ci      <= 1'b0;
      bus.flag_c      <= 1'b0;
      bus.flag_z      <= 1'b0;
      bus.flag_n      <= 1'b0;
      bus.illegal_op  <= 1'b0;
    end else begin
      bus.illegal_op <= 1'b0;
      case (state)
        IDLE: if (bus.instr_valid) begin
          if (legal) begin
            bus.alu_opcode  <= op;
            bus.alu_data_rd <= bus.rf_rd_data;
            bus.alu_data_rr <= bus.rf_rr_data;
            bus.alu_ci      <= bus.flag_c;
            rd              <= bus.instr[7:4];
            cnt             <= '0;
            state           <= EXEC;
          end else begin
            bus.illegal_op <= 1'b1;
          end
        end
        EXEC: begin
          cnt   <= cnt + 1'b1;
          state <= cnt == LAST ? WB_LO : EXEC;
        end
        WB_LO: begin
          bus.flag_c <= bus.alu_co;
          bus.flag_z <= bus.alu_zo;
          bus.flag_n <= bus.alu_no;
          state      <= mult ? WB_HI : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef ALU_SEQ_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) bus.op_count <= '0;
    else if (state == IDLE && bus.instr_valid && legal) bus.op_count <= bus.op_count + 1'b1;
  end
`else
  assign bus.op_count = '0;
`endif
endmodule
